alu_exception_unit: RTL and testbench

- Sequential consumer of the ALU's 8-bit status word.
- Qualifies invalid_address, div_zero and overflow per instruction, latches cause/EPC/bad address, and runs a request/acknowledge/return handshake with the control unit.
- Also keeps sticky condition flags and a saturating exception counter.
- Sits between the ALU and the main control FSM, in the role of a minimal coprocessor-0 cause/EPC block.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/exc_priority_enc.sv | 37 +++
 rtl/alu_exception_unit.sv | 116 +++++++++++
 tb/tb_alu_exception_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the ALU exception path: status bit positions,
// cause codes and the exception state encoding.
package cpu_pkg;

  localparam int unsigned ST_ZERO    = 7;
  localparam int unsigned ST_OVF     = 6;
  localparam int unsigned ST_CARRY   = 5;
  localparam int unsigned ST_NEG     = 4;
  localparam int unsigned ST_INVADDR = 3;
  localparam int unsigned ST_DIVZ    = 2;

  localparam logic [3:0] CAUSE_ADEL = 4'd4;
  localparam logic [3:0] CAUSE_ADES = 4'd5;
  localparam logic [3:0] CAUSE_DIVZ = 4'd9;
  localparam logic [3:0] CAUSE_OVF  = 4'd12;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    IN_HANDLER
  } exc_state_t;

endpackage

// File: rtl/exc_priority_enc.sv
// Qualifies ALU status against the instruction's trap enables and picks
// the highest-priority cause: address > divide-by-zero > overflow.
module exc_priority_enc
  import cpu_pkg::*;
#(
  parameter logic [3:0] CAUSE_ADEL = cpu_pkg::CAUSE_ADEL,
  parameter logic [3:0] CAUSE_ADES = cpu_pkg::CAUSE_ADES,
  parameter logic [3:0] CAUSE_DIVZ = cpu_pkg::CAUSE_DIVZ,
  parameter logic [3:0] CAUSE_OVF  = cpu_pkg::CAUSE_OVF
) (
  input  logic       status_valid,
  input  logic [7:2] status,
  input  logic       chk_ovf,
  input  logic       chk_addr,
  input  logic       chk_div,
  input  logic       is_store,
  output logic       hit,
  output logic [3:0] cause
);

  logic addr_exc;
  logic divz_exc;
  logic ovf_exc;

  assign addr_exc = status_valid & chk_addr & status[ST_INVADDR];
  assign divz_exc = status_valid & chk_div  & status[ST_DIVZ];
  assign ovf_exc  = status_valid & chk_ovf  & status[ST_OVF];
  assign hit      = addr_exc | divz_exc | ovf_exc;

  always_comb begin
    cause = '0;
    if (addr_exc)      cause = is_store ? CAUSE_ADES : CAUSE_ADEL;
    else if (divz_exc) cause = CAUSE_DIVZ;
    else if (ovf_exc)  cause = CAUSE_OVF;
  end

endmodule

// File: rtl/alu_exception_unit.sv
// Coprocessor-0 style cause/EPC block: captures qualified ALU exceptions and
// runs the request/ack/return handshake with the control unit.
module alu_exception_unit
  import cpu_pkg::*;
#(
  parameter int unsigned COUNT_W    = 8,
  parameter logic [3:0]  CAUSE_ADEL = cpu_pkg::CAUSE_ADEL,
  parameter logic [3:0]  CAUSE_ADES = cpu_pkg::CAUSE_ADES,
  parameter logic [3:0]  CAUSE_DIVZ = cpu_pkg::CAUSE_DIVZ,
  parameter logic [3:0]  CAUSE_OVF  = cpu_pkg::CAUSE_OVF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               status_valid,
  input  logic [7:0]         ALU_status,
  input  logic [31:0]        ALU_result,
  input  logic [31:0]        instr_pc,
  input  logic               chk_ovf,
  input  logic               chk_addr,
  input  logic               chk_div,
  input  logic               is_store,
  input  logic               exc_ack,
  input  logic               eret,
  output logic               exc_req,
  output logic [3:0]         exc_cause,
  output logic [31:0]        epc,
  output logic [31:0]        bad_vaddr,
  output logic               in_handler,
  output logic               exc_lost,
  output logic [3:0]         flags,
  output logic [COUNT_W-1:0] exc_count
);

  exc_state_t state, state_next;
  logic       hit;
  logic [3:0] hit_cause;
  logic       capture;
  logic       set_lost;
  logic       clr_lost;
  logic       unused_status;

  assign unused_status = ^ALU_status[1:0];

  exc_priority_enc #(
    .CAUSE_ADEL(CAUSE_ADEL),
    .CAUSE_ADES(CAUSE_ADES),
    .CAUSE_DIVZ(CAUSE_DIVZ),
    .CAUSE_OVF (CAUSE_OVF)
  ) u_prio (
    .status_valid(status_valid),
    .status      (ALU_status[7:2]),
    .chk_ovf     (chk_ovf),
    .chk_addr    (chk_addr),
    .chk_div     (chk_div),
    .is_store    (is_store),
    .hit         (hit),
    .cause       (hit_cause)
  );

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    set_lost   = 1'b0;
    clr_lost   = 1'b0;
    unique case (state)
      IDLE: begin
        if (hit) begin
          capture    = 1'b1;
          state_next = PENDING;
        end
      end
      PENDING: begin
        set_lost = hit;
        if (exc_ack) state_next = IN_HANDLER;
      end
      IN_HANDLER: begin
        // eret retires the handler first, so a same-cycle hit is a fresh capture
        if (eret) begin
          clr_lost   = 1'b1;
          capture    = hit;
          state_next = hit ? PENDING : IDLE;
        end else begin
          set_lost = hit;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      exc_cause <= '0;
      epc       <= '0;
      bad_vaddr <= '0;
      exc_lost  <= 1'b0;
      flags     <= '0;
      exc_count <= '0;
    end else begin
      state <= state_next;
      if (status_valid) flags <= ALU_status[ST_ZERO:ST_NEG];
      if (capture) begin
        exc_cause <= hit_cause;
        epc       <= instr_pc;
        bad_vaddr <= ALU_result;
        if (exc_count != '1) exc_count <= exc_count + 1'b1;
      end
      if (set_lost)      exc_lost <= 1'b1;
      else if (clr_lost) exc_lost <= 1'b0;
    end
  end

  assign exc_req    = (state == PENDING);
  assign in_handler = (state == IN_HANDLER);

endmodule

// File: tb/tb_alu_exception_unit.sv
// Randomised scoreboard bench: driver pushes model predictions, monitor
// compares them against two instances (8-bit and 2-bit counters).
module tb_alu_exception_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        status_valid;
  logic [7:0]  ALU_status;
  logic [31:0] ALU_result;
  logic [31:0] instr_pc;
  logic        chk_ovf, chk_addr, chk_div, is_store, exc_ack, eret;

  logic        exc_req_a, in_handler_a, exc_lost_a;
  logic [3:0]  exc_cause_a, flags_a;
  logic [31:0] epc_a, bad_vaddr_a;
  logic [7:0]  exc_count_a;

  logic        exc_req_b, in_handler_b, exc_lost_b;
  logic [3:0]  exc_cause_b, flags_b;
  logic [31:0] epc_b, bad_vaddr_b;
  logic [1:0]  exc_count_b;

  always #5 clk = ~clk;

  alu_exception_unit #(.COUNT_W(8)) dut (
    .clk(clk), .reset(reset), .status_valid(status_valid), .ALU_status(ALU_status),
    .ALU_result(ALU_result), .instr_pc(instr_pc), .chk_ovf(chk_ovf), .chk_addr(chk_addr),
    .chk_div(chk_div), .is_store(is_store), .exc_ack(exc_ack), .eret(eret),
    .exc_req(exc_req_a), .exc_cause(exc_cause_a), .epc(epc_a), .bad_vaddr(bad_vaddr_a),
    .in_handler(in_handler_a), .exc_lost(exc_lost_a), .flags(flags_a), .exc_count(exc_count_a)
  );

  alu_exception_unit #(.COUNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .status_valid(status_valid), .ALU_status(ALU_status),
    .ALU_result(ALU_result), .instr_pc(instr_pc), .chk_ovf(chk_ovf), .chk_addr(chk_addr),
    .chk_div(chk_div), .is_store(is_store), .exc_ack(exc_ack), .eret(eret),
    .exc_req(exc_req_b), .exc_cause(exc_cause_b), .epc(epc_b), .bad_vaddr(bad_vaddr_b),
    .in_handler(in_handler_b), .exc_lost(exc_lost_b), .flags(flags_b), .exc_count(exc_count_b)
  );

  typedef struct packed {
    logic        req;
    logic        hand;
    logic        lost;
    logic [3:0]  cause;
    logic [3:0]  flg;
    logic [31:0] pc;
    logic [31:0] bad;
    logic [7:0]  cnt8;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // reference model state
  bit          m_pend, m_hand, m_lost;
  logic [3:0]  m_cause, m_flags;
  logic [31:0] m_epc, m_bad;
  int          m_cnt8, m_cnt2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step();
    bit         a, d, o, hit, cap;
    logic [3:0] c;
    if (reset) begin
      m_pend = 0; m_hand = 0; m_lost = 0;
      m_cause = 0; m_flags = 0; m_epc = 0; m_bad = 0; m_cnt8 = 0; m_cnt2 = 0;
      return;
    end
    a   = status_valid && chk_addr && ALU_status[3];
    d   = status_valid && chk_div  && ALU_status[2];
    o   = status_valid && chk_ovf  && ALU_status[6];
    hit = a || d || o;
    c   = a ? (is_store ? 4'd5 : 4'd4) : d ? 4'd9 : 4'd12;
    if (status_valid) m_flags = ALU_status[7:4];
    cap = 0;
    if (m_pend) begin
      if (hit) m_lost = 1;
      if (exc_ack) begin m_pend = 0; m_hand = 1; end
    end else if (m_hand) begin
      if (eret) begin
        m_lost = 0; m_hand = 0;
        cap = hit;
      end else if (hit) m_lost = 1;
    end else begin
      cap = hit;
    end
    if (cap) begin
      m_pend = 1; m_cause = c; m_epc = instr_pc; m_bad = ALU_result;
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  task automatic cyc(input logic sv, input logic [7:0] st, input logic [31:0] res,
                     input logic [31:0] pc, input logic co, input logic ca, input logic cd,
                     input logic s, input logic ack, input logic er, input logic rst);
    exp_t e;
    @(negedge clk);
    status_valid = sv; ALU_status = st; ALU_result = res; instr_pc = pc;
    chk_ovf = co; chk_addr = ca; chk_div = cd; is_store = s;
    exc_ack = ack; eret = er; reset = rst;
    model_step();
    e.req = m_pend; e.hand = m_hand; e.lost = m_lost; e.cause = m_cause; e.flg = m_flags;
    e.pc = m_epc; e.bad = m_bad; e.cnt8 = 8'(m_cnt8); e.cnt2 = 2'(m_cnt2);
    q.push_back(e);
  endtask

  task automatic idle();
    cyc(0, 8'h00, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        vectors++;
        check("exc_req",      32'(exc_req_a),    32'(e.req));
        check("in_handler",   32'(in_handler_a), 32'(e.hand));
        check("exc_lost",     32'(exc_lost_a),   32'(e.lost));
        check("exc_cause",    32'(exc_cause_a),  32'(e.cause));
        check("flags",        32'(flags_a),      32'(e.flg));
        check("epc",          epc_a,             e.pc);
        check("bad_vaddr",    bad_vaddr_a,       e.bad);
        check("exc_count",    32'(exc_count_a),  32'(e.cnt8));
        check("exc_count_w2", 32'(exc_count_b),  32'(e.cnt2));
        check("exc_req_w2",   32'(exc_req_b),    32'(e.req));
        check("epc_w2",       epc_b,             e.pc);
      end
    end
  end

  initial begin : driver
    cyc(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    // overflow trap, acknowledge, return
    cyc(1, 8'h40, 32'h0000_1234, 32'h0040_0010, 1, 0, 0, 0, 0, 0, 0);
    idle();
    cyc(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    // priority: address beats div and overflow, store then load
    cyc(1, 8'h4C, 32'h1000_0003, 32'h0040_0020, 1, 1, 1, 1, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 8'h4C, 32'h1000_0003, 32'h0040_0024, 1, 1, 1, 0, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    // unqualified status only updates flags
    cyc(1, 8'hFC, 32'hDEAD_BEEF, 32'h0040_0030, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // lost exception in PENDING, then eret with simultaneous div-zero hit
    cyc(1, 8'h40, 32'h0000_0001, 32'h0040_0040, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 8'h04, 32'h0000_0002, 32'h0040_0044, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 8'h08, 32'h0000_0003, 32'h0040_0048, 0, 1, 0, 0, 1, 0, 0);
    cyc(1, 8'h40, 32'h0000_0004, 32'h0040_004C, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 8'h04, 32'h0000_0005, 32'h0040_0050, 0, 0, 1, 0, 0, 1, 0);
    idle();
    // reset mid-PENDING with three accepted exceptions
    cyc(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 8'h04, 32'(i), 32'h0040_0100 + 32'(i * 4), 0, 0, 1, 0, 0, 0, 0);
      if (i < 2) begin
        cyc(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      end
    end
    cyc(1, 8'h40, 0, 0, 1, 0, 0, 0, 1, 1, 1);
    idle();
    // saturation of both counter widths via back-to-back eret+hit
    cyc(1, 8'h40, 32'h0, 32'h0040_0200, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      cyc(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc(1, 8'h40, $urandom, $urandom, 1, 0, 0, 0, 0, 1, 0);
    end
    cyc(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 9) < 7), 8'($urandom), $urandom, $urandom,
          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2),
          ($urandom_range(0, 499) == 0));
    end
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
